// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: quarter/half-frame pulses, $4017 mode/inhibit, frame IRQ (FRAME_IRQ_EN enables IRQ logic).
// Latency: pulses one clk after the count match; counter restarts WR_DLY clks after a $4017 write.
// Backpressure: none, every write and ack strobe is accepted in the cycle it arrives.
module apu_frame_sequencer #(
    parameter int CNT_W  = 16,
    parameter int STEP1  = 7457,
    parameter int STEP2  = 14913,
    parameter int STEP3  = 22371,
    parameter int STEP4  = 29829,
    parameter int STEP5  = 37281,
    parameter int WR_DLY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic       mode
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;
    localparam int DLY_W = (WR_DLY > 2) ? $clog2(WR_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(WR_DLY - 1);

    logic [0:0]       state;
    logic [DLY_W-1:0] dly;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] lastCyc;
    logic             restart;
    logic             atStep1, atStep2, atStep3, atStep4, atStep5;
    logic             quarterDec, halfDec;

    // A write landing on the restart cycle reloads the delay instead of restarting.
    assign restart = (state == PENDING) && (dly == '0) && !wr_en;
    assign lastCyc = mode ? CNT_W'(STEP5) : CNT_W'(STEP4);

    assign atStep1 = (cyc == CNT_W'(STEP1));
    assign atStep2 = (cyc == CNT_W'(STEP2));
    assign atStep3 = (cyc == CNT_W'(STEP3));
    assign atStep4 = (cyc == CNT_W'(STEP4));
    assign atStep5 = (cyc == CNT_W'(STEP5));

    assign quarterDec = atStep1 || atStep2 || atStep3 || (atStep4 && !mode) || (atStep5 && mode);
    assign halfDec    = atStep2 || (atStep4 && !mode) || (atStep5 && mode);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc           <= '0;
            mode          <= 1'b0;
            state         <= RUN;
            dly           <= '0;
            quarter_frame <= 1'b0;
            half_frame    <= 1'b0;
        end else begin
            if (restart) begin
                cyc           <= '0;
                state         <= RUN;
                quarter_frame <= mode;
                half_frame    <= mode;
            end else begin
                cyc           <= (cyc == lastCyc) ? '0 : cyc + 1'b1;
                quarter_frame <= quarterDec;
                half_frame    <= halfDec;
                if (state == PENDING) begin
                    dly <= dly - 1'b1;
                end
            end
            if (wr_en) begin
                mode  <= wr_data[7];
                state <= PENDING;
                dly   <= DLY_LOAD;
            end
        end
    end

`ifdef FRAME_IRQ_EN
    logic inhibit;
    logic irqSet;
    logic unusedBits;

    assign irqSet     = !restart && atStep4 && !mode && !inhibit;
    assign unusedBits = ^wr_data[5:0];

    // Inhibit write beats a same-cycle set, which beats an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit   <= 1'b0;
            frame_irq <= 1'b0;
        end else begin
            if (wr_en) begin
                inhibit <= wr_data[6];
            end
            if (wr_en && wr_data[6]) begin
                frame_irq <= 1'b0;
            end else if (irqSet) begin
                frame_irq <= 1'b1;
            end else if (irq_ack) begin
                frame_irq <= 1'b0;
            end
        end
    end
`else
    logic unusedBits;

    assign frame_irq  = 1'b0;
    assign unusedBits = ^{wr_data[6:0], irq_ack};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: position/deadline reference model plus directed pulse-time checks.
module tb_apu_frame_sequencer;
    localparam int CNT_W  = 16;
    localparam int STEP1  = 7457;
    localparam int STEP2  = 14913;
    localparam int STEP3  = 22371;
    localparam int STEP4  = 29829;
    localparam int STEP5  = 37281;
    localparam int WR_DLY = 3;
`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       irq_ack = 1'b0;
    logic       quarter_frame, half_frame, frame_irq, mode;

    apu_frame_sequencer #(
        .CNT_W(CNT_W), .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3),
        .STEP4(STEP4), .STEP5(STEP5), .WR_DLY(WR_DLY)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .irq_ack(irq_ack),
        .quarter_frame(quarter_frame), .half_frame(half_frame),
        .frame_irq(frame_irq), .mode(mode)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    bit     checkEn = 1'b0;
    longint edgeNo = 0;

    // Model: position since last restart, plus the absolute edge at which a pending restart fires.
    int     pos = 0, mMode = 0, mInh = 0, mIrq = 0, mQ = 0, mH = 0;
    longint restartAt = -1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edgeNo);
        end
    endtask

    task automatic step();
        bit restartNow;
        bit setIrq;
        int last;
        @(posedge clk);
        edgeNo++;
        if (reset) begin
            pos = 0; mMode = 0; mInh = 0; mIrq = 0; mQ = 0; mH = 0; restartAt = -1;
        end else begin
            restartNow = (restartAt == edgeNo) && !wr_en;
            setIrq = 1'b0;
            if (restartNow) begin
                mQ = mMode; mH = mMode; pos = 0; restartAt = -1;
            end else begin
                mQ = (pos == STEP1 || pos == STEP2 || pos == STEP3 ||
                      (pos == STEP4 && mMode == 0) || (pos == STEP5 && mMode == 1)) ? 1 : 0;
                mH = (pos == STEP2 || (pos == STEP4 && mMode == 0) ||
                      (pos == STEP5 && mMode == 1)) ? 1 : 0;
                setIrq = (pos == STEP4 && mMode == 0 && mInh == 0);
                last = (mMode == 1) ? STEP5 : STEP4;
                pos = (pos == last) ? 0 : (pos + 1) % (1 << CNT_W);
            end
            if (IRQ_EN) begin
                if (wr_en && wr_data[6]) mIrq = 0;
                else if (setIrq) mIrq = 1;
                else if (irq_ack) mIrq = 0;
            end
            if (wr_en) begin
                mMode = wr_data[7]; mInh = wr_data[6]; restartAt = edgeNo + WR_DLY;
            end
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] d, input logic a);
        reset = r; wr_en = w; wr_data = d; irq_ack = a;
        step();
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("quarter", quarter_frame, mQ);
            check("half", half_frame, mH);
            check("irq", frame_irq, mIrq);
            check("mode", mode, mMode);
        end
    end

    int aQ[4] = '{7457, 14913, 22371, 29829};
    int aH[2] = '{14913, 29829};
    int cQ[5] = '{3, 7461, 14917, 22375, 37285};
    int cH[3] = '{3, 14917, 37285};
    int qLog[$];
    int hLog[$];

    initial begin
        // Reset state
        drive(1, 0, 8'h00, 0);
        checkEn = 1'b1;
        drive(1, 0, 8'h00, 0);
        check("rst_quarter", quarter_frame, 0);
        check("rst_half", half_frame, 0);
        check("rst_irq", frame_irq, 0);
        check("rst_mode", mode, 0);

        // 4-step period; ack coincident with the IRQ set, then a plain ack 5 cycles later
        for (int rel = 0; rel <= 29840; rel++) begin
            drive(0, 0, 8'h00, (rel == 29829 || rel == 29834));
            if (quarter_frame) qLog.push_back(rel);
            if (half_frame) hLog.push_back(rel);
            if (rel == 29829) check("irq_set_with_ack", frame_irq, IRQ_EN);
            if (rel == 29833) check("irq_hold", frame_irq, IRQ_EN);
            if (rel == 29834) check("irq_ack_clear", frame_irq, 0);
        end
        check("m0_qcount", qLog.size(), 4);
        check("m0_hcount", hLog.size(), 2);
        for (int i = 0; i < 4; i++) if (i < qLog.size()) check("m0_qtime", qLog[i], aQ[i]);
        for (int i = 0; i < 2; i++) if (i < hLog.size()) check("m0_htime", hLog[i], aH[i]);

        // Back-to-back writes give one restart; reset during pending discards it
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 50; i++) drive(0, 0, 8'h00, 0);
        qLog.delete(); hLog.delete();
        for (int d = 0; d <= 12; d++) begin
            drive(0, (d < 2), (d == 1) ? 8'h80 : 8'h00, 0);
            if (quarter_frame) qLog.push_back(d);
            if (half_frame) hLog.push_back(d);
        end
        check("dbl_qcount", qLog.size(), 1);
        check("dbl_hcount", hLog.size(), 1);
        if (qLog.size() > 0) check("dbl_qtime", qLog[0], 4);
        check("dbl_mode", mode, 1);
        drive(0, 1, 8'h80, 0);
        drive(1, 0, 8'h00, 0);
        qLog.delete();
        for (int d = 0; d < 10; d++) begin
            drive(0, 0, 8'h00, 0);
            if (quarter_frame) qLog.push_back(d);
        end
        check("rstpend_qcount", qLog.size(), 0);
        check("rstpend_mode", mode, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic r, w, a;
            r = ($urandom % 500) == 0;
            w = !r && (($urandom % 40) == 0);
            a = ($urandom % 8) == 0;
            drive(r, w, 8'($urandom), a);
        end

        // 5-step mode: write 8'h80 at cycle 100 after reset
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 100; i++) drive(0, 0, 8'h00, 0);
        qLog.delete(); hLog.delete();
        for (int d = 0; d <= 37290; d++) begin
            drive(0, (d == 0), 8'h80, 0);
            if (quarter_frame) qLog.push_back(d);
            if (half_frame) hLog.push_back(d);
        end
        check("m1_qcount", qLog.size(), 5);
        check("m1_hcount", hLog.size(), 3);
        for (int i = 0; i < 5; i++) if (i < qLog.size()) check("m1_qtime", qLog[i], cQ[i]);
        for (int i = 0; i < 3; i++) if (i < hLog.size()) check("m1_htime", hLog[i], cH[i]);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
